// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the arbitrated 16-bit add/subtract block:
//   state_t  - controller states (IDLE, CALC, HOLD)
//   ADD/SUB  - values of the per-requester add_ctrl bit
//   WIDTH_C  - operand width of the shared slice (fixed at 16)
// ---------------------------------------------------------------------------
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int WIDTH_C = 16;

endpackage

// File: rtl/addsub_16.sv
// ---------------------------------------------------------------------------
// addsub_16
// Combinational 16-bit add/subtract slice.
//   a, b      in  16 : operands
//   add_ctrl  in  1  : ADD (0) or SUB (1)
//   sum       out 16 : result
//   c_out     out 1  : carry out on add, no-borrow (a >= b) on subtract
//   o         out 1  : two's-complement overflow
// ---------------------------------------------------------------------------
module addsub_16
    import adder_arb_pkg::*;
(
    input  logic [WIDTH_C-1:0] a,
    input  logic [WIDTH_C-1:0] b,
    input  logic               add_ctrl,
    output logic [WIDTH_C-1:0] sum,
    output logic               c_out,
    output logic               o
);

    logic [WIDTH_C-1:0] b_eff;
    logic [WIDTH_C:0]   total;

    // Subtract is A + ~B + 1, so the carry out is the no-borrow flag and
    // overflow reduces to the add rule applied to the effective B operand.
    always_comb begin
        b_eff = (add_ctrl == SUB) ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH_C{1'b0}}, add_ctrl};
        sum   = total[WIDTH_C-1:0];
        c_out = total[WIDTH_C];
        o     = (a[WIDTH_C-1] == b_eff[WIDTH_C-1]) &&
                (sum[WIDTH_C-1] != a[WIDTH_C-1]);
    end

endmodule

// File: rtl/adder_arb_16.sv
// ---------------------------------------------------------------------------
// adder_arb_16
// Shares one 16-bit add/subtract slice among N_REQ requesters. A round-robin
// arbiter grants one requester in IDLE, its operands are registered, the
// slice result is captured in CALC and held on the response port in HOLD
// until rsp_ready.
//
// Build option: define ADDER_ARB_FIXED_PRI_EN for fixed priority (lowest
// index wins, no round-robin pointer).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid   in  N_REQ       request pending per requester
//   req_ready   out N_REQ       one-hot grant (combinational, IDLE only)
//   req_A/req_B in  N_REQ*WIDTH operands, requester i at [16i+15:16i]
//   req_add_ctrl in N_REQ       0 = add, 1 = subtract
//   rsp_valid   out 1           result held
//   rsp_ready   in  1           consumer accepts the result
//   rsp_id      out ID_W        granted requester index
//   rsp_SUM, rsp_C_out, rsp_O   result, carry/no-borrow, overflow
// ---------------------------------------------------------------------------
module adder_arb_16
    import adder_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = WIDTH_C,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_A,
    input  logic [N_REQ*WIDTH-1:0] req_B,
    input  logic [N_REQ-1:0]       req_add_ctrl,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_SUM,
    output logic                   rsp_C_out,
    output logic                   rsp_O
);

    if (WIDTH != WIDTH_C) begin : g_width_chk
        $error("adder_arb_16 supports WIDTH == 16 only");
    end

    state_t state, state_nxt;

    logic            found;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] grant;
    logic            take;

    logic [WIDTH-1:0] a_p0, b_p0;
    logic             op_p0;
    logic [ID_W-1:0]  id_p0;

    logic [WIDTH-1:0] sum_p1;
    logic             c_p1, o_p1;

`ifndef ADDER_ARB_FIXED_PRI_EN
    logic [ID_W-1:0] rr_ptr;
`endif

    // Scan requesters starting at the priority head; the first valid wins.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ADDER_ARB_FIXED_PRI_EN
            scan_idx = ID_W'(k);
`else
            scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
`endif
            if (!found && req_valid[scan_idx]) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end

    assign take = (state == IDLE) && found;

    // Gated by rst_n so no grant is advertised while reset is asserted.
    assign req_ready = (take && rst_n) ? (N_REQ'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)     state_nxt = CALC;
            CALC:                   state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: operands of the granted requester ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= ADD;
            id_p0 <= '0;
`ifndef ADDER_ARB_FIXED_PRI_EN
            rr_ptr <= '0;
`endif
        end else if (take) begin
            a_p0  <= req_A[int'(grant)*WIDTH +: WIDTH];
            b_p0  <= req_B[int'(grant)*WIDTH +: WIDTH];
            op_p0 <= req_add_ctrl[grant];
            id_p0 <= grant;
`ifndef ADDER_ARB_FIXED_PRI_EN
            rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
`endif
        end
    end

    addsub_16 u_addsub (
        .a        (a_p0),
        .b        (b_p0),
        .add_ctrl (op_p0),
        .sum      (sum_p1),
        .c_out    (c_p1),
        .o        (o_p1)
    );

    // ---- stage p1: response registers, held until accepted ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_SUM   <= '0;
            rsp_C_out <= 1'b0;
            rsp_O     <= 1'b0;
        end else if (state == CALC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_p0;
            rsp_SUM   <= sum_p1;
            rsp_C_out <= c_p1;
            rsp_O     <= o_p1;
        end else if ((state == HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arb_16.sv
// ---------------------------------------------------------------------------
// tb_adder_arb_16
// Directed and randomized checks of adder_arb_16 with N_REQ = 4.
// ---------------------------------------------------------------------------
module tb_adder_arb_16;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*16-1:0] req_A;
    logic [N*16-1:0] req_B;
    logic [N-1:0]  req_add_ctrl;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_SUM;
    logic          rsp_C_out;
    logic          rsp_O;

    int n_tests = 0;
    int n_fail  = 0;

    adder_arb_16 #(.N_REQ(N), .WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_A        (req_A),
        .req_B        (req_B),
        .req_add_ctrl (req_add_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_SUM      (rsp_SUM),
        .rsp_C_out    (rsp_C_out),
        .rsp_O        (rsp_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic op);
        req_A[idx*16 +: 16]  = a;
        req_B[idx*16 +: 16]  = b;
        req_add_ctrl[idx]    = op;
    endtask

    // One isolated transaction from requester idx; checks timing and result.
    task automatic run_single(input string tag, input int idx,
                              input logic [15:0] a, input logic [15:0] b, input logic op,
                              input logic [15:0] e_sum, input logic e_c, input logic e_o);
        set_req(idx, a, b, op);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        rsp_ready      = 1'b0;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(1 << idx));
        step();
        // operands change after acceptance must not matter
        req_valid = '0;
        set_req(idx, ~a, ~b, ~op);
        #1;
        check({tag, ".vld_calc"}, 32'(rsp_valid), 0);
        check({tag, ".ready_calc"}, 32'(req_ready), 0);
        step();
        check({tag, ".vld"}, 32'(rsp_valid), 1);
        check({tag, ".id"}, 32'(rsp_id), 32'(idx));
        check({tag, ".sum"}, 32'(rsp_SUM), 32'(e_sum));
        check({tag, ".c"}, 32'(rsp_C_out), 32'(e_c));
        check({tag, ".o"}, 32'(rsp_O), 32'(e_o));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check({tag, ".vld_done"}, 32'(rsp_valid), 0);
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
        logic [16:0] t;
        logic [15:0] s;
        logic        c, o;
        if (!op) begin
            t = {1'b0, a} + {1'b0, b};
            s = t[15:0];
            c = t[16];
            o = (a[15] == b[15]) && (s[15] != a[15]);
        end else begin
            s = a - b;
            c = (a >= b);
            o = (a[15] != b[15]) && (s[15] != a[15]);
        end
        return {o, c, s};
    endfunction

    initial begin
        logic [15:0] ra[N];
        logic [15:0] rb[N];
        logic        rop[N];
        int          exp_ids[6];
        int          got, last, ptr, g;
        logic [3:0]  m;
        logic [17:0] e;

        rst_n        = 1'b0;
        req_valid    = '1;
        req_A        = '0;
        req_B        = '0;
        req_add_ctrl = '0;
        rsp_ready    = 1'b0;
        step();
        check("rst.vld", 32'(rsp_valid), 0);
        check("rst.id", 32'(rsp_id), 0);
        check("rst.sum", 32'(rsp_SUM), 0);
        check("rst.c", 32'(rsp_C_out), 0);
        check("rst.o", 32'(rsp_O), 0);
        check("rst.ready", 32'(req_ready), 0);
        do_reset();

        // Directed arithmetic vectors
        run_single("t1",  0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("t2a", 2, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_single("t2b", 2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_single("carry", 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("negovf", 3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_single("subeq", 0, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0);

        // All requesters valid, rsp_ready tied high
        do_reset();
`ifdef ADDER_ARB_FIXED_PRI_EN
        exp_ids = '{0, 0, 0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 2, 3, 0, 1};
`endif
        rsp_ready = 1'b1;
        req_valid = '1;
        got  = 0;
        last = -1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            step();
            if (rsp_valid) begin
                check($sformatf("rr.id%0d", got), 32'(rsp_id), 32'(exp_ids[got]));
                if (got > 0) check($sformatf("rr.gap%0d", got), 32'(c - last), 3);
                last = c;
                got++;
            end
        end
        check("rr.count", 32'(got), 6);
        req_valid = '0;
        for (int c = 0; c < 4; c++) step();
        rsp_ready = 1'b0;

        // Backpressure in HOLD
        do_reset();
        set_req(1, 16'h0003, 16'h0005, 1'b1);
        req_valid = 4'b0010;
        #1;
        check("bp.ready", 32'(req_ready), 'h2);
        step();
        req_valid = '0;
        step();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp.vld%0d", k), 32'(rsp_valid), 1);
            check($sformatf("bp.id%0d", k), 32'(rsp_id), 1);
            check($sformatf("bp.sum%0d", k), 32'(rsp_SUM), 'hFFFE);
            check($sformatf("bp.c%0d", k), 32'(rsp_C_out), 0);
            check($sformatf("bp.o%0d", k), 32'(rsp_O), 0);
            check($sformatf("bp.rdy%0d", k), 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.rdy_accept", 32'(req_ready), 0);
        step();
        rsp_ready = 1'b0;
        #1;
        check("bp.vld_idle", 32'(rsp_valid), 0);
`ifdef ADDER_ARB_FIXED_PRI_EN
        check("bp.next_grant", 32'(req_ready), 'h1);
`else
        check("bp.next_grant", 32'(req_ready), 'h4);
`endif
        req_valid = '0;
        #1;

        // Reset during CALC
        do_reset();
        run_single("pre", 3, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        set_req(1, 16'h7FFF, 16'h7FFF, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("rc.ready", 32'(req_ready), 'h2);
        step();
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        check("rc.vld", 32'(rsp_valid), 0);
        check("rc.id", 32'(rsp_id), 0);
        check("rc.sum", 32'(rsp_SUM), 0);
        check("rc.c", 32'(rsp_C_out), 0);
        check("rc.o", 32'(rsp_O), 0);
        check("rc.ready", 32'(req_ready), 0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rc.novld%0d", k), 32'(rsp_valid), 0);
        end
        req_valid = '1;
        #1;
        check("rc.first_grant", 32'(req_ready), 'h1);
        req_valid = '0;
        #1;

        // Random patterns against the behavioural model
        do_reset();
        ptr       = 0;
        rsp_ready = 1'b1;
        for (int it = 0; it < 10000; it++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                ra[i]  = 16'($urandom);
                rb[i]  = 16'($urandom);
                rop[i] = 1'($urandom_range(0, 1));
                set_req(i, ra[i], rb[i], rop[i]);
            end
            req_valid = m;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
`ifdef ADDER_ARB_FIXED_PRI_EN
                j = k;
`else
                j = (ptr + k) % N;
`endif
                if (g < 0 && m[j]) g = j;
            end
            e = model(ra[g], rb[g], rop[g]);
            #1;
            check("rnd.ready", 32'(req_ready), 32'(1 << g));
            step();
`ifndef ADDER_ARB_FIXED_PRI_EN
            ptr = (g + 1) % N;
`endif
            for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            req_valid = 4'($urandom_range(0, 15));
            #1;
            check("rnd.ready_calc", 32'(req_ready), 0);
            step();
            check("rnd.id", 32'(rsp_id), 32'(g));
            check("rnd.sum", 32'(rsp_SUM), 32'(e[15:0]));
            check("rnd.c", 32'(rsp_C_out), 32'(e[16]));
            check("rnd.o", 32'(rsp_O), 32'(e[17]));
            req_valid = '0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
